// File: rtl/wf_res_arbiter_if.sv
// Request/grant bundle between wavefront requesters and the shared-resource arbiter.
// The requester side is the master; the arbiter is the slave.
interface wf_res_arbiter_if #(
    parameter int NUM_REQ = 8,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0] req;
    logic               done;
    logic               clr_err;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_id;
    logic               timeout_err;
    logic               busy;

    modport master (
        output req, done, clr_err,
        input  gnt, gnt_valid, gnt_id, timeout_err, busy
    );

    modport slave (
        input  req, done, clr_err,
        output gnt, gnt_valid, gnt_id, timeout_err, busy
    );
endinterface

// File: rtl/wf_res_arbiter.sv
// Round-robin arbiter for one multi-cycle resource shared by NUM_REQ wavefronts.
// A grant is held until done, or force-released by the hold watchdog.
module wf_res_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int ID_W     = 3,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    wf_res_arbiter_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [ID_W:0]    NREQ      = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ-1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD-1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W:0]        off, sum;
    logic [ID_W-1:0]      sel, id_inc;
    logic                 found;

    // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
    assign dbl = {bus.req, bus.req} >> ptr_q;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = (ID_W+1)'(i);
            end
        end
        sum = {1'b0, ptr_q} + off;
        if (sum >= NREQ) sum = sum - NREQ;
        sel = sum[ID_W-1:0];
    end

    assign id_inc = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        err_d   = err_q & ~bus.clr_err;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = HOLD;
                    gnt_d   = NUM_REQ'(1) << sel;
                    id_d    = sel;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (bus.done || cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                    vld_d   = 1'b0;
                    ptr_d   = id_inc;
                    // A timeout overrides a simultaneous clr_err.
                    if (!bus.done) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.gnt_valid   = vld_q;
    assign bus.gnt_id      = id_q;
    assign bus.busy        = vld_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_wf_res_arbiter.sv
// Directed bench for wf_res_arbiter: reset, round-robin order, hold, watchdog and async reset.
module tb_wf_res_arbiter;
    localparam int NUM_REQ  = 8;
    localparam int ID_W     = 3;
    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 16;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    wf_res_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bi ();

    wf_res_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic [7:0] g, input logic [2:0] id, input logic b);
        chk({tag, ".gnt"},  64'(bi.gnt),       64'(g));
        chk({tag, ".id"},   64'(bi.gnt_id),    64'(id));
        chk({tag, ".busy"}, 64'(bi.busy),      64'(b));
        chk({tag, ".vld"},  64'(bi.gnt_valid), 64'(b));
    endtask

    // Structural invariants, sampled away from the active edge.
    always @(negedge clk) begin
        logic [7:0] exp_g;
        exp_g = bi.gnt_valid ? (8'h01 << bi.gnt_id) : 8'h00;
        chk("inv.onehot0", 64'($onehot0(bi.gnt)), 64'(1));
        chk("inv.vld",     64'(bi.gnt_valid),    64'(|bi.gnt));
        chk("inv.busy",    64'(bi.busy),         64'(bi.gnt_valid));
        chk("inv.id",      64'(bi.gnt),          64'(exp_g));
    end

    initial begin
        rst_n = 1'b1; bi.req = '0; bi.done = 1'b0; bi.clr_err = 1'b0;
        #2 rst_n = 1'b0; bi.req = 8'hFF;
        #1;
        chk_gnt("rst0", 8'h00, 3'd0, 1'b0);
        chk("rst0.err", 64'(bi.timeout_err), 64'(0));
        tick();
        chk_gnt("rst1", 8'h00, 3'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_gnt("first", 8'h01, 3'd0, 1'b1);
        bi.done = 1'b1;
        tick();
        bi.done = 1'b0; bi.req = 8'h81;
        chk_gnt("first.rel", 8'h00, 3'd0, 1'b0);

        // ptr=1: 7,0,7,0 with one idle cycle between grants
        for (int k = 0; k < 4; k++) begin
            logic [2:0] eid;
            eid = (k % 2 == 0) ? 3'd7 : 3'd0;
            tick();
            chk_gnt($sformatf("wrap%0d", k), 8'h01 << eid, eid, 1'b1);
            tick();
            chk_gnt($sformatf("wrap%0d.hold", k), 8'h01 << eid, eid, 1'b1);
            bi.done = 1'b1;
            tick();
            bi.done = 1'b0;
            chk_gnt($sformatf("wrap%0d.idle", k), 8'h00, 3'd0, 1'b0);
        end

        // pointer skip: ptr=1 -> grant 2 -> ptr=3
        bi.req = 8'h04;
        tick();
        chk_gnt("skip.g2", 8'h04, 3'd2, 1'b1);
        bi.done = 1'b1; tick(); bi.done = 1'b0;
        bi.req = 8'h06;
        tick();
        chk_gnt("skip.g1", 8'h02, 3'd1, 1'b1);
        bi.done = 1'b1; tick(); bi.done = 1'b0;
        bi.req = 8'h18;
        tick();
        chk_gnt("skip.g3", 8'h08, 3'd3, 1'b1);
        bi.done = 1'b1; tick(); bi.done = 1'b0;

        // hold stability: ptr=4, grant 5, then req switches to bit 0
        bi.req = 8'h20;
        tick();
        chk_gnt("hold.g5", 8'h20, 3'd5, 1'b1);
        bi.req = 8'h01;
        tick();
        chk_gnt("hold.c1", 8'h20, 3'd5, 1'b1);
        tick();
        chk_gnt("hold.c2", 8'h20, 3'd5, 1'b1);
        bi.done = 1'b1; tick(); bi.done = 1'b0;
        chk_gnt("hold.rel", 8'h00, 3'd0, 1'b0);
        tick();
        chk_gnt("hold.g0", 8'h01, 3'd0, 1'b1);
        bi.req = 8'h00;
        bi.done = 1'b1; tick(); bi.done = 1'b0;

        // done while idle is ignored
        bi.done = 1'b1; tick(); bi.done = 1'b0;
        chk_gnt("idle.done", 8'h00, 3'd0, 1'b0);

        // timeout: ptr=1, grant 2, no done for 4 HOLD cycles
        bi.req = 8'h04;
        tick();
        chk_gnt("to.g2", 8'h04, 3'd2, 1'b1);
        bi.req = 8'h00;
        tick(); tick(); tick();
        chk_gnt("to.c3", 8'h04, 3'd2, 1'b1);
        chk("to.c3.err", 64'(bi.timeout_err), 64'(0));
        tick();
        chk_gnt("to.rel", 8'h00, 3'd0, 1'b0);
        chk("to.err", 64'(bi.timeout_err), 64'(1));
        bi.clr_err = 1'b1; tick(); bi.clr_err = 1'b0;
        chk("clr.err", 64'(bi.timeout_err), 64'(0));

        // clr_err on the timeout edge: set wins (ptr=3)
        bi.req = 8'h08;
        tick();
        chk_gnt("toclr.g3", 8'h08, 3'd3, 1'b1);
        bi.req = 8'h00;
        tick(); tick(); tick();
        bi.clr_err = 1'b1;
        tick();
        bi.clr_err = 1'b0;
        chk_gnt("toclr.rel", 8'h00, 3'd0, 1'b0);
        chk("toclr.err", 64'(bi.timeout_err), 64'(1));
        bi.clr_err = 1'b1; tick(); bi.clr_err = 1'b0;
        chk("toclr.clr", 64'(bi.timeout_err), 64'(0));

        // done on the last hold cycle is a normal release (ptr=4)
        bi.req = 8'h10;
        tick();
        chk_gnt("lastdone.g4", 8'h10, 3'd4, 1'b1);
        bi.req = 8'h00;
        tick(); tick(); tick();
        bi.done = 1'b1;
        tick();
        bi.done = 1'b0;
        chk_gnt("lastdone.rel", 8'h00, 3'd0, 1'b0);
        chk("lastdone.err", 64'(bi.timeout_err), 64'(0));

        // async reset mid-HOLD (ptr=5, req bit 4 wraps to grant 4)
        bi.req = 8'h10;
        tick();
        chk_gnt("arst.g4", 8'h10, 3'd4, 1'b1);
        bi.req = 8'h00;
        #3 rst_n = 1'b0;
        #1;
        chk_gnt("arst.now", 8'h00, 3'd0, 1'b0);
        #2 rst_n = 1'b1; bi.req = 8'h11;
        tick();
        chk_gnt("arst.ptr0", 8'h01, 3'd0, 1'b1);
        chk("arst.err", 64'(bi.timeout_err), 64'(0));
        bi.req = 8'h00;
        bi.done = 1'b1; tick(); bi.done = 1'b0;
        chk_gnt("end.idle", 8'h00, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
